// File: rtl/bus_pkg.sv
// Shared definitions for the bus endpoint: destination field layout,
// broadcast address and occupancy counter type.
package bus_pkg;

    localparam int unsigned DST_W         = 8;
    localparam logic [DST_W-1:0] BCAST_DEFAULT = 8'hFF;
    localparam int unsigned PKT_MAX       = 64;
    localparam int unsigned DEPTH_DEFAULT = 8;

    typedef logic [$clog2(DEPTH_DEFAULT):0] cnt_t;

    // Destination ID lives in the top DST_W bits of a pkt_w-bit packet;
    // the packet is passed zero-extended to PKT_MAX bits.
    function automatic logic [DST_W-1:0] dst_of(input logic [PKT_MAX-1:0] pkt,
                                                input int unsigned     pkt_w);
        logic [PKT_MAX-1:0] shifted;
        shifted = pkt >> (pkt_w - DST_W);
        return shifted[DST_W-1:0];
    endfunction

endpackage

// File: rtl/bus_endpoint_fifo_if.sv
// Bus-side handshake between the arbiter (master) and one endpoint (slave).
interface bus_endpoint_fifo_if #(
    parameter int unsigned pckg_sz = 16
);
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;

    modport master (input pndng, D_pop, output pop, push, D_push);
    modport slave  (output pndng, D_pop, input pop, push, D_push);
endinterface

// File: rtl/bus_endpoint_fifo_pckg_fifo.sv
// Circular-buffer packet queue with first-word fall-through output,
// separate occupancy counter, and drop/underflow event pulses.
module pckg_fifo #(
    parameter int unsigned pckg_sz = 16,
    parameter int unsigned depth   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  logic [pckg_sz-1:0]     din,
    input  logic                   rd,
    output logic [pckg_sz-1:0]     dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] count,
    output logic                   ovf_pulse,
    output logic                   unf_pulse
);
    localparam int unsigned PTR_W = $clog2(depth);

    logic [pckg_sz-1:0] mem [depth];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_rd;
    logic               do_wr;

    // A pop frees a slot in the same cycle, so a full queue still takes a
    // push when it is also being read; a read on empty never frees one.
    always_comb begin
        full      = (count == (PTR_W+1)'(depth));
        empty     = (count == '0);
        do_rd     = rd && !empty;
        do_wr     = wr && (!full || do_rd);
        ovf_pulse = wr && !do_wr;
        unf_pulse = rd && empty;
        dout      = empty ? '0 : mem[rd_ptr];
    end

    // Pointers wrap naturally at depth (power of two); count tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (do_rd && !do_wr) count <= count - 1'b1;
        end
    end

    // Storage array; contents are don't-care while not covered by count.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bus_endpoint_fifo.sv
// Bus endpoint: TX queue drained by the arbiter, RX queue filled from the
// bus through a destination filter, plus sticky error flags.
module bus_endpoint_fifo
    import bus_pkg::*;
#(
    parameter int unsigned      pckg_sz   = 16,
    parameter int unsigned      depth     = 8,
    parameter logic [DST_W-1:0] id        = 8'd0,
    parameter logic [DST_W-1:0] broadcast = BCAST_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    bus_endpoint_fifo_if.slave      bus,
    input  logic                    dev_push,
    input  logic [pckg_sz-1:0]      dev_din,
    output logic                    tx_full,
    output logic [$clog2(depth):0]  tx_count,
    input  logic                    dev_pop,
    output logic [pckg_sz-1:0]      dev_dout,
    output logic                    rx_empty,
    output logic [$clog2(depth):0]  rx_count,
    output logic                    tx_ovf,
    output logic                    rx_ovf,
    output logic                    pop_unf,
    output logic [7:0]              misroute_cnt,
    input  logic                    clr_err
);
    logic             tx_empty;
    logic             tx_ovf_p;
    logic             tx_unf_p;
    logic             rx_full;
    logic             rx_ovf_p;
    logic             rx_unf_unused;
    logic [DST_W-1:0] dst;
    logic             accept;
    logic             misroute;

    pckg_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_tx (
        .clk       (clk),
        .reset     (reset),
        .wr        (dev_push),
        .din       (dev_din),
        .rd        (bus.pop),
        .dout      (bus.D_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .ovf_pulse (tx_ovf_p),
        .unf_pulse (tx_unf_p)
    );

    pckg_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .wr        (accept),
        .din       (bus.D_push),
        .rd        (dev_pop),
        .dout      (dev_dout),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count),
        .ovf_pulse (rx_ovf_p),
        .unf_pulse (rx_unf_unused)
    );

    // Destination filter: keep packets addressed to us or to broadcast.
    always_comb begin
        dst       = dst_of(PKT_MAX'(bus.D_push), pckg_sz);
        accept    = bus.push && ((dst == id) || (dst == broadcast));
        misroute  = bus.push && !accept;
        bus.pndng = !tx_empty;
    end

    // Sticky flags and saturating misroute counter; clear wins over set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_ovf       <= 1'b0;
            rx_ovf       <= 1'b0;
            pop_unf      <= 1'b0;
            misroute_cnt <= '0;
        end else if (clr_err) begin
            tx_ovf       <= 1'b0;
            rx_ovf       <= 1'b0;
            pop_unf      <= 1'b0;
            misroute_cnt <= '0;
        end else begin
            tx_ovf  <= tx_ovf  | tx_ovf_p;
            rx_ovf  <= rx_ovf  | rx_ovf_p;
            pop_unf <= pop_unf | tx_unf_p;
            if (misroute && (misroute_cnt != '1)) misroute_cnt <= misroute_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_bus_endpoint_fifo.sv
// Self-checking bench for bus_endpoint_fifo (id=2, depth=8, 16-bit packets):
// directed vector table, hand-written corner sequences, then randomized
// traffic checked against a queue-based reference model.
module tb_bus_endpoint_fifo;
    import bus_pkg::*;

    localparam int unsigned PW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam logic [7:0]  MY_ID = 8'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic          dev_push;
    logic [PW-1:0] dev_din;
    logic          tx_full;
    cnt_t          tx_count;
    logic          dev_pop;
    logic [PW-1:0] dev_dout;
    logic          rx_empty;
    cnt_t          rx_count;
    logic          tx_ovf;
    logic          rx_ovf;
    logic          pop_unf;
    logic [7:0]    misroute_cnt;
    logic          clr_err;

    bus_endpoint_fifo_if #(.pckg_sz(PW)) bus ();

    bus_endpoint_fifo #(
        .pckg_sz   (PW),
        .depth     (DEPTH),
        .id        (MY_ID),
        .broadcast (8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .dev_push     (dev_push),
        .dev_din      (dev_din),
        .tx_full      (tx_full),
        .tx_count     (tx_count),
        .dev_pop      (dev_pop),
        .dev_dout     (dev_dout),
        .rx_empty     (rx_empty),
        .rx_count     (rx_count),
        .tx_ovf       (tx_ovf),
        .rx_ovf       (rx_ovf),
        .pop_unf      (pop_unf),
        .misroute_cnt (misroute_cnt),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic          dp;
        logic [PW-1:0] din;
        logic          pp;
        logic          bp;
        logic [PW-1:0] bd;
        logic          dvp;
        logic          clr;
        cnt_t          e_txc;
        logic          e_pndng;
        logic [PW-1:0] e_dpop;
        cnt_t          e_rxc;
        logic [PW-1:0] e_dout;
        logic [2:0]    e_flags;   // {tx_ovf, rx_ovf, pop_unf}
        logic [7:0]    e_mis;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic dp, input logic [PW-1:0] din, input logic pp,
                         input logic bp, input logic [PW-1:0] bd, input logic dvp,
                         input logic clr);
        dev_push    = dp;
        dev_din     = din;
        bus.pop     = pp;
        bus.push    = bp;
        bus.D_push  = bd;
        dev_pop     = dvp;
        clr_err     = clr;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int txc, input logic [PW-1:0] dpop,
                           input int rxc, input logic [PW-1:0] dout,
                           input logic [2:0] flags, input logic [7:0] mis);
        chk({tag, ".tx_count"}, 32'(tx_count), 32'(txc));
        chk({tag, ".pndng"},    32'(bus.pndng), 32'(txc != 0));
        chk({tag, ".tx_full"},  32'(tx_full), 32'(txc == DEPTH));
        chk({tag, ".D_pop"},    32'(bus.D_pop), 32'(dpop));
        chk({tag, ".rx_count"}, 32'(rx_count), 32'(rxc));
        chk({tag, ".rx_empty"}, 32'(rx_empty), 32'(rxc == 0));
        chk({tag, ".dev_dout"}, 32'(dev_dout), 32'(dout));
        chk({tag, ".flags"},    32'({tx_ovf, rx_ovf, pop_unf}), 32'(flags));
        chk({tag, ".misroute"}, 32'(misroute_cnt), 32'(mis));
    endtask

    // Reference model state
    logic [PW-1:0] txq [$];
    logic [PW-1:0] rxq [$];
    logic [2:0]    m_flags;
    logic [7:0]    m_mis;

    initial begin
        // Directed table: dp din pp bp bd dvp clr | txc pndng D_pop rxc dout flags mis
        vt[0]  = '{1'b1, 16'h0101, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd1, 1'b1, 16'h0101, 4'd0, 16'h0000, 3'b000, 8'd0};
        vt[1]  = '{1'b1, 16'h0202, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd2, 1'b1, 16'h0101, 4'd0, 16'h0000, 3'b000, 8'd0};
        vt[2]  = '{1'b1, 16'h0303, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd3, 1'b1, 16'h0101, 4'd0, 16'h0000, 3'b000, 8'd0};
        vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd2, 1'b1, 16'h0202, 4'd0, 16'h0000, 3'b000, 8'd0};
        vt[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd1, 1'b1, 16'h0303, 4'd0, 16'h0000, 3'b000, 8'd0};
        vt[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 16'h0000, 3'b000, 8'd0};
        vt[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0255, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd1, 16'h0255, 3'b000, 8'd0};
        vt[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFF66, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd2, 16'h0255, 3'b000, 8'd0};
        vt[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0377, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd2, 16'h0255, 3'b000, 8'd1};
        vt[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd1, 16'hFF66, 3'b000, 8'd1};
        vt[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 16'h0000, 3'b000, 8'd1};
        vt[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 16'h0000, 3'b001, 8'd1};
        vt[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 4'd0, 16'h0000, 3'b000, 8'd0};

        // Reset state
        reset = 1'b1;
        idle();
        cyc();
        chk_all("reset", 0, 16'h0000, 0, 16'h0000, 3'b000, 8'd0);
        cyc();
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].dp, vt[i].din, vt[i].pp, vt[i].bp, vt[i].bd, vt[i].dvp, vt[i].clr);
            cyc();
            chk_all($sformatf("vec%0d", i), int'(vt[i].e_txc), vt[i].e_dpop, int'(vt[i].e_rxc),
                    vt[i].e_dout, vt[i].e_flags, vt[i].e_mis);
        end
        idle();

        // TX full: ninth push dropped and never appears
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(16'hA000 + i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
            cyc();
        end
        chk("fullA.tx_full", 32'(tx_full), 32'd1);
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc();
        idle();
        chk("ovfA.tx_ovf", 32'(tx_ovf), 32'd1);
        chk("ovfA.tx_count", 32'(tx_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drainA%0d", i), 32'(bus.D_pop), 32'(16'(16'hA000 + i)));
            drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            cyc();
        end
        idle();
        chk("drainA.pndng", 32'(bus.pndng), 32'd0);
        chk("drainA.D_pop", 32'(bus.D_pop), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        cyc();
        idle();

        // TX full with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(16'hB000 + i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
            cyc();
        end
        drive(1'b1, 16'hBEEF, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        cyc();
        idle();
        chk("pushpopB.tx_count", 32'(tx_count), 32'd8);
        chk("pushpopB.tx_ovf", 32'(tx_ovf), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drainB%0d", i), 32'(bus.D_pop),
                (i < 7) ? 32'(16'(16'hB001 + i)) : 32'h0000BEEF);
            drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            cyc();
        end
        idle();
        chk("drainB.tx_count", 32'(tx_count), 32'd0);

        // RX full: overflow drop, then push with same-cycle dev_pop
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
            cyc();
        end
        drive(1'b0, '0, 1'b0, 1'b1, 16'h02AA, 1'b0, 1'b0);
        cyc();
        chk("ovfC.rx_ovf", 32'(rx_ovf), 32'd1);
        chk("ovfC.rx_count", 32'(rx_count), 32'd8);
        drive(1'b0, '0, 1'b0, 1'b1, 16'h02BB, 1'b1, 1'b0);
        cyc();
        idle();
        chk("pushpopC.rx_count", 32'(rx_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drainC%0d", i), 32'(dev_dout),
                (i < 7) ? 32'(16'(16'h0201 + i)) : 32'h000002BB);
            drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
            cyc();
        end
        idle();
        chk("drainC.rx_empty", 32'(rx_empty), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        cyc();
        idle();

        // Asynchronous reset with traffic queued both ways
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(16'hC000 + i), 1'b0, 1'b1, 16'(16'hFF00 + i), 1'b0, 1'b0);
            cyc();
        end
        drive(1'b0, '0, 1'b0, 1'b1, 16'h0377, 1'b0, 1'b0);
        cyc();
        idle();
        chk("preD.tx_count", 32'(tx_count), 32'd4);
        chk("preD.misroute", 32'(misroute_cnt), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("asyncD", 0, 16'h0000, 0, 16'h0000, 3'b000, 8'd0);
        cyc();
        reset = 1'b0;

        // Randomized traffic against the queue model
        m_flags = '0;
        m_mis   = '0;
        for (int c = 0; c < 3000; c++) begin
            logic          dp, pp, bp, dvp, clr;
            logic [PW-1:0] din, bd;
            logic [7:0]    dst;
            logic          acc, tx_pop_ok, tx_do_push, rx_pop_ok, rx_do_push;
            logic          fill_phase;
            fill_phase = ((c / 400) % 2) == 0;
            dp  = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            pp  = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            bp  = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            dvp = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 399) == 0);
            din = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       dst = MY_ID;
                1:       dst = 8'hFF;
                default: dst = 8'($urandom);
            endcase
            bd = {dst, 8'($urandom)};

            tx_pop_ok  = pp && (txq.size() > 0);
            tx_do_push = dp && ((txq.size() < DEPTH) || tx_pop_ok);
            acc        = bp && ((bd[15:8] == MY_ID) || (bd[15:8] == 8'hFF));
            rx_pop_ok  = dvp && (rxq.size() > 0);
            rx_do_push = acc && ((rxq.size() < DEPTH) || rx_pop_ok);

            if (clr) begin
                m_flags = '0;
                m_mis   = '0;
            end else begin
                if (dp && !tx_do_push)      m_flags[2] = 1'b1;
                if (acc && !rx_do_push)     m_flags[1] = 1'b1;
                if (pp && txq.size() == 0)  m_flags[0] = 1'b1;
                if (bp && !acc && m_mis < 8'd255) m_mis = m_mis + 8'd1;
            end
            if (tx_pop_ok)  void'(txq.pop_front());
            if (tx_do_push) txq.push_back(din);
            if (rx_pop_ok)  void'(rxq.pop_front());
            if (rx_do_push) rxq.push_back(bd);

            drive(dp, din, pp, bp, bd, dvp, clr);
            cyc();
            chk_all($sformatf("rnd%0d", c),
                    txq.size(), (txq.size() > 0) ? txq[0] : 16'h0000,
                    rxq.size(), (rxq.size() > 0) ? rxq[0] : 16'h0000,
                    m_flags, m_mis);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_endpoint_fifo.md
Name: bus_endpoint_fifo

Overview:
- One bus endpoint per driver slot of the bus generator/arbiter.
- TX side: the device pushes packets into a queue. The queue presents pndng/D_pop to the bus, and the arbiter drains it with pop.
- RX side: accepts bus push/D_push, filters on destination ID, and queues packets for the device to read.
- The bench instantiates drvrs copies, id = 0..drvrs-1, in place of the behavioural driver FIFOs.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1 -: 8] carry the destination ID.
- depth, 8, entries per queue; power of 2, ≥2.
- id, 0, this endpoint's 8-bit address.
- broadcast, 8'hFF, destination ID accepted by every endpoint.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- dev_push  in  1  device writes dev_din into the TX queue.
- dev_din  in  pckg_sz  TX packet.
- tx_full  out  1  TX queue full.
- tx_count  out  $clog2(depth)+1  TX occupancy.
- pndng  out  1  to bus: TX queue non-empty.
- D_pop  out  pckg_sz  to bus: TX head packet, first-word fall-through.
- pop  in  1  from bus: consume the TX head.
- push  in  1  from bus: D_push is valid this cycle.
- D_push  in  pckg_sz  from bus: delivered packet.
- dev_pop  in  1  device consumes the RX head.
- dev_dout  out  pckg_sz  RX head packet, first-word fall-through.
- rx_empty  out  1  RX queue empty.
- rx_count  out  $clog2(depth)+1  RX occupancy.
- tx_ovf  out  1  sticky: a device push was dropped.
- rx_ovf  out  1  sticky: a bus push was dropped because RX was full.
- pop_unf  out  1  sticky: bus popped while pndng=0.
- misroute_cnt  out  8  saturating count of filtered bus packets.
- clr_err  in  1  synchronous clear of all sticky flags and misroute_cnt.

Behaviour:
- Reset state (asynchronous, immediate):
  - Both queues empty and pointers zero.
  - pndng=0, tx_full=0, rx_empty=1, counts=0.
  - D_pop=0, dev_dout=0, all flags 0, misroute_cnt=0.
  - Reset mid-transfer discards all queued data; there is no drain.
- Each queue is a circular buffer:
  - Read/write pointers are $clog2(depth) bits and wrap from depth-1 to 0.
  - Occupancy is a separate counter of $clog2(depth)+1 bits.
  - full = (count==depth); empty = (count==0).
- TX write: when dev_push=1 and (!tx_full or pop&&pndng in the same cycle), store dev_din at the write pointer.
  - If dev_push=1 while full with no same-cycle pop, the packet is dropped and tx_ovf is set.
- TX read: when pop=1 and pndng=1, advance the read pointer; the count decrements.
  - The new head appears on D_pop in the following cycle.
  - If pop=1 and pndng=0, nothing changes and pop_unf is set.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - On an empty queue, a same-cycle push and pop is a pop on empty: pop_unf is set and the push is stored.
- Output timing:
  - D_pop = mem[rd_ptr] when pndng=1, else 0.
  - pndng rises in the cycle after the first dev_push into an empty queue (1-cycle latency).
- RX filter: on push=1, let dst = D_push[pckg_sz-1 -: 8].
  - If dst==id or dst==broadcast, enqueue D_push.
  - Otherwise drop it and increment misroute_cnt, saturating at 255.
- RX write and read:
  - Accepted push while rx full (no same-cycle dev_pop): drop and set rx_ovf.
  - dev_pop on empty: ignored, no flag.
  - Same full/empty simultaneity rules as TX.
- Clear behaviour:
  - clr_err has priority over a same-cycle set: flags and counter end the cycle at 0.
  - clr_err does not touch queue contents.
- No data transformation: packets exit bit-identical to how they entered, in FIFO order per queue.

Decomposition:
- Shared package bus_pkg holds:
  - localparam DST_W=8 and BCAST_DEFAULT=8'hFF.
  - A function dst_of(pkt) returning the top DST_W bits.
  - typedef cnt_t for the occupancy width.
- One sub-module, pckg_fifo, parameterised by pckg_sz and depth.
  - Ports: wr, din, rd, dout, full, empty, count, ovf_pulse, unf_pulse.
  - Instantiated twice, once for TX and once for RX.
- The top level adds the destination filter, sticky flags and misroute counter.

Test Plan:
- After reset, push 3 packets 16'h0101, 16'h0202, 16'h0303 on dev_push.
  - Expect pndng=1 one cycle after the first push and D_pop=16'h0101.
  - Three pops return 0101, 0202, 0303 in order; then pndng=0.
- Fill TX with 8 packets, then push a 9th with no pop.
  - Expect tx_full=1, tx_ovf=1, tx_count=8, and the 9th packet never appears on D_pop.
- Fill TX, then assert dev_push and pop in the same cycle.
  - Expect tx_count to stay 8, no tx_ovf, and the new packet to emerge last.
- With id=2, send bus pushes with D_push=16'h0255, 16'hFF66 and 16'h0377.
  - Expect rx_count=2 and dev_dout order 0255, FF66.
  - Expect misroute_cnt=1.
- Assert pop with the TX queue empty.
  - Expect pop_unf=1 and tx_count=0.
  - Then assert clr_err together with another underflow: pop_unf=0 next cycle.
- Assert reset asynchronously mid-cycle with 4 packets queued in each direction.
  - Expect pndng=0, rx_empty=1, counts=0 and flags=0 immediately, without waiting for a clock edge.
